hci_shared_port_arbiter: RTL and testbench

Two-way arbiter that shares one TCDM-style memory port between a core-side requester and an HWPE-side requester. It is configured at run time by an `hci_interconnect_ctrl_t` word. That word selects:
- fixed priority with a bounded-starvation guard,
- round-robin, or
- fixed priority with no guard.

It sits between the HWPE streamer/core interconnect branches and a single memory bank or port, and routes the 1-cycle-latency response back to the owner of the request.

---
 rtl/hci_shared_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_hci_shared_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hci_shared_port_arbiter.sv
// Two-way arbiter sharing one TCDM-style memory port between a core and an HWPE requester.
// Policy (guarded fixed priority, round-robin, plain fixed priority) is selected at run time.

typedef struct packed {
    logic [1:0] arb_policy;
    logic       hwpe_prio;
    logic [7:0] low_prio_max_stall;
} hci_interconnect_ctrl_t;

module hci_shared_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 8
) (
    input  logic                   clk_i,
    input  logic                   clear_i,
    input  hci_interconnect_ctrl_t ctrl_i,

    input  logic                   core_req_i,
    output logic                   core_gnt_o,
    input  logic [AW-1:0]          core_add_i,
    input  logic                   core_wen_i,
    input  logic [DW-1:0]          core_data_i,
    input  logic [DW/BW-1:0]       core_be_i,
    output logic [DW-1:0]          core_r_data_o,
    output logic                   core_r_valid_o,

    input  logic                   hwpe_req_i,
    output logic                   hwpe_gnt_o,
    input  logic [AW-1:0]          hwpe_add_i,
    input  logic                   hwpe_wen_i,
    input  logic [DW-1:0]          hwpe_data_i,
    input  logic [DW/BW-1:0]       hwpe_be_i,
    output logic [DW-1:0]          hwpe_r_data_o,
    output logic                   hwpe_r_valid_o,

    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AW-1:0]          mem_add_o,
    output logic                   mem_wen_o,
    output logic [DW-1:0]          mem_data_o,
    output logic [DW/BW-1:0]       mem_be_o,
    input  logic [DW-1:0]          mem_r_data_i,
    input  logic                   mem_r_valid_i
);

    typedef enum logic {
        SIDE_CORE = 1'b0,
        SIDE_HWPE = 1'b1
    } side_e;

    localparam logic [1:0] POLICY_FIXED_GUARD = 2'b00;
    localparam logic [1:0] POLICY_RR          = 2'b01;

    side_e      rr_q, rr_d;
    side_e      owner_q;
    logic       pend_q;
    logic [7:0] stall_q, stall_d;

    side_e      win;
    side_e      high_side, low_side;
    logic       both_req, handshake, guard_fire, low_req, low_hs;

    assign high_side = ctrl_i.hwpe_prio ? SIDE_HWPE : SIDE_CORE;
    assign low_side  = ctrl_i.hwpe_prio ? SIDE_CORE : SIDE_HWPE;
    assign both_req  = core_req_i & hwpe_req_i;
    assign mem_req_o = core_req_i | hwpe_req_i;
    assign handshake = mem_req_o & mem_gnt_i;

    // The starvation guard only ever fires once the counter reaches a nonzero limit.
    assign guard_fire = (ctrl_i.arb_policy == POLICY_FIXED_GUARD) &&
                        (ctrl_i.low_prio_max_stall != 8'd0) &&
                        (stall_q == ctrl_i.low_prio_max_stall);

    always_comb begin
        win = SIDE_CORE;
        if (both_req) begin
            case (ctrl_i.arb_policy)
                POLICY_FIXED_GUARD: win = guard_fire ? low_side : high_side;
                POLICY_RR:          win = rr_q;
                default:            win = high_side;
            endcase
        end else if (hwpe_req_i) begin
            win = SIDE_HWPE;
        end
    end

    assign core_gnt_o = core_req_i & (win == SIDE_CORE) & mem_gnt_i;
    assign hwpe_gnt_o = hwpe_req_i & (win == SIDE_HWPE) & mem_gnt_i;

    always_comb begin
        mem_add_o  = core_add_i;
        mem_wen_o  = core_wen_i;
        mem_data_o = core_data_i;
        mem_be_o   = core_be_i;
        if (win == SIDE_HWPE) begin
            mem_add_o  = hwpe_add_i;
            mem_wen_o  = hwpe_wen_i;
            mem_data_o = hwpe_data_i;
            mem_be_o   = hwpe_be_i;
        end
    end

    assign low_req = (low_side == SIDE_HWPE) ? hwpe_req_i : core_req_i;
    assign low_hs  = handshake && (win == low_side);

    // A lowered limit clamps the counter so the guard still fires.
    always_comb begin
        stall_d = stall_q;
        if ((ctrl_i.arb_policy != POLICY_FIXED_GUARD) || !low_req || low_hs) begin
            stall_d = 8'd0;
        end else if (stall_q >= ctrl_i.low_prio_max_stall) begin
            stall_d = ctrl_i.low_prio_max_stall;
        end else begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if ((ctrl_i.arb_policy == POLICY_RR) && handshake && both_req) begin
            rr_d = (win == SIDE_CORE) ? SIDE_HWPE : SIDE_CORE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            stall_q <= 8'd0;
            rr_q    <= SIDE_CORE;
            owner_q <= SIDE_CORE;
            pend_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            rr_q    <= rr_d;
            pend_q  <= handshake;
            if (handshake) begin
                owner_q <= win;
            end
        end
    end

    assign core_r_data_o  = mem_r_data_i;
    assign hwpe_r_data_o  = mem_r_data_i;
    assign core_r_valid_o = mem_r_valid_i & pend_q & (owner_q == SIDE_CORE);
    assign hwpe_r_valid_o = mem_r_valid_i & pend_q & (owner_q == SIDE_HWPE);

endmodule

// File: tb/tb_hci_shared_port_arbiter.sv
// Directed bench for hci_shared_port_arbiter: grant order per policy, response routing
// through a scoreboard of expected responses, and clear behaviour.

module tb_hci_shared_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam logic [31:0] CORE_ADD = 32'h0000_0100;
    localparam logic [31:0] HWPE_ADD = 32'h0000_0200;

    typedef struct {
        logic        hwpe;
        logic        drop;
        logic [31:0] data;
    } rsp_t;

    logic                   clk;
    logic                   clear_i;
    hci_interconnect_ctrl_t ctrl_i;
    logic                   core_req_i, core_gnt_o, core_wen_i, core_r_valid_o;
    logic [AW-1:0]          core_add_i;
    logic [DW-1:0]          core_data_i, core_r_data_o;
    logic [DW/BW-1:0]       core_be_i;
    logic                   hwpe_req_i, hwpe_gnt_o, hwpe_wen_i, hwpe_r_valid_o;
    logic [AW-1:0]          hwpe_add_i;
    logic [DW-1:0]          hwpe_data_i, hwpe_r_data_o;
    logic [DW/BW-1:0]       hwpe_be_i;
    logic                   mem_req_o, mem_gnt_i, mem_wen_o, mem_r_valid_i;
    logic [AW-1:0]          mem_add_o;
    logic [DW-1:0]          mem_data_o, mem_r_data_i;
    logic [DW/BW-1:0]       mem_be_o;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];

    hci_shared_port_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
        .clk_i          (clk),
        .clear_i        (clear_i),
        .ctrl_i         (ctrl_i),
        .core_req_i     (core_req_i),
        .core_gnt_o     (core_gnt_o),
        .core_add_i     (core_add_i),
        .core_wen_i     (core_wen_i),
        .core_data_i    (core_data_i),
        .core_be_i      (core_be_i),
        .core_r_data_o  (core_r_data_o),
        .core_r_valid_o (core_r_valid_o),
        .hwpe_req_i     (hwpe_req_i),
        .hwpe_gnt_o     (hwpe_gnt_o),
        .hwpe_add_i     (hwpe_add_i),
        .hwpe_wen_i     (hwpe_wen_i),
        .hwpe_data_i    (hwpe_data_i),
        .hwpe_be_i      (hwpe_be_i),
        .hwpe_r_data_o  (hwpe_r_data_o),
        .hwpe_r_valid_o (hwpe_r_valid_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_add_o      (mem_add_o),
        .mem_wen_o      (mem_wen_o),
        .mem_data_o     (mem_data_o),
        .mem_be_o       (mem_be_o),
        .mem_r_data_i   (mem_r_data_i),
        .mem_r_valid_i  (mem_r_valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input logic [1:0] policy, input logic prio, input logic [7:0] max_stall);
        ctrl_i.arb_policy         = policy;
        ctrl_i.hwpe_prio          = prio;
        ctrl_i.low_prio_max_stall = max_stall;
    endtask

    // One clock of stimulus; exp names the expected winner: "C", "H" or "N" (no request).
    task automatic step(input logic creq, input logic hreq, input logic gnt, input logic clr,
                        input byte exp);
        rsp_t        e;
        logic        hs;
        logic [31:0] d;
        core_req_i = creq;
        hwpe_req_i = hreq;
        mem_gnt_i  = gnt;
        clear_i    = clr;
        @(negedge clk);
        check("mem_req", 32'(mem_req_o), 32'(creq | hreq));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("core_r_valid", 32'(core_r_valid_o), 32'(!e.drop && !e.hwpe));
            check("hwpe_r_valid", 32'(hwpe_r_valid_o), 32'(!e.drop && e.hwpe));
            check("core_r_data", core_r_data_o, e.data);
            check("hwpe_r_data", hwpe_r_data_o, e.data);
        end else begin
            check("core_r_valid_idle", 32'(core_r_valid_o), 32'd0);
            check("hwpe_r_valid_idle", 32'(hwpe_r_valid_o), 32'd0);
        end
        if (exp != "N") begin
            check("core_gnt", 32'(core_gnt_o), 32'(exp == "C" && gnt));
            check("hwpe_gnt", 32'(hwpe_gnt_o), 32'(exp == "H" && gnt));
            check("mem_add", mem_add_o, (exp == "H") ? HWPE_ADD : CORE_ADD);
            check("mem_wen", 32'(mem_wen_o), 32'(exp != "H"));
        end
        hs = (exp != "N") && gnt;
        d  = $urandom;
        if (hs) sb.push_back('{hwpe: (exp == "H"), drop: clr, data: d});
        @(posedge clk);
        #1;
        mem_r_valid_i = hs;
        mem_r_data_i  = d;
    endtask

    initial begin
        core_req_i    = 1'b0;
        hwpe_req_i    = 1'b0;
        core_add_i    = CORE_ADD;
        hwpe_add_i    = HWPE_ADD;
        core_wen_i    = 1'b1;
        hwpe_wen_i    = 1'b0;
        core_data_i   = 32'hC0DE_0001;
        hwpe_data_i   = 32'hFEED_0002;
        core_be_i     = '1;
        hwpe_be_i     = 4'b0011;
        mem_gnt_i     = 1'b0;
        mem_r_valid_i = 1'b0;
        mem_r_data_i  = '0;
        clear_i       = 1'b1;
        set_ctrl(2'b00, 1'b1, 8'd3);

        // Reset, then idle state with nothing pending
        step(1'b0, 1'b0, 1'b0, 1'b1, "N");
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        // Single core read, response one cycle later
        step(1'b1, 1'b0, 1'b1, 1'b0, "C");
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        // Guarded fixed priority, HWPE high, limit 3: H,H,H,C repeating
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "H");
            step(1'b1, 1'b1, 1'b1, 1'b0, "C");
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        // Guard disabled with a zero limit: core never granted
        set_ctrl(2'b00, 1'b1, 8'd0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "H");
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        // Round-robin from reset, with a two-cycle memory stall in the middle
        step(1'b0, 1'b0, 1'b1, 1'b1, "N");
        set_ctrl(2'b01, 1'b1, 8'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, "C");
        step(1'b1, 1'b1, 1'b1, 1'b0, "H");
        step(1'b1, 1'b1, 1'b0, 1'b0, "C");
        step(1'b1, 1'b1, 1'b0, 1'b0, "C");
        step(1'b1, 1'b1, 1'b1, 1'b0, "C");
        step(1'b1, 1'b1, 1'b1, 1'b0, "H");
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        // Alternating owners: each response routed to its own requester
        step(1'b1, 1'b0, 1'b1, 1'b0, "C");
        step(1'b0, 1'b1, 1'b1, 1'b0, "H");
        step(1'b1, 1'b0, 1'b1, 1'b0, "C");
        step(1'b0, 1'b1, 1'b1, 1'b0, "H");
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        // Clear with HWPE handshaking: response dropped, round-robin back to core
        step(1'b1, 1'b1, 1'b1, 1'b0, "C");
        step(1'b0, 1'b1, 1'b1, 1'b1, "H");
        step(1'b1, 1'b1, 1'b1, 1'b0, "C");
        step(1'b1, 1'b1, 1'b1, 1'b0, "H");
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        // Clear with stall counter at 2: full H,H,H,C run needed afterwards
        set_ctrl(2'b00, 1'b1, 8'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, "H");
        step(1'b1, 1'b1, 1'b1, 1'b0, "H");
        step(1'b1, 1'b1, 1'b1, 1'b1, "H");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "H");
        step(1'b1, 1'b1, 1'b1, 1'b0, "C");
        step(1'b0, 1'b0, 1'b1, 1'b0, "N");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
